top_decryption: RTL and testbench
=================================

TOP_DECRYPTION -- requirements
Module: top_decryption

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all logic on rising edge.
REQ-002 SHALL have ports: reset_n  in  1  synchronous, active-low reset.
REQ-003 SHALL have ports: in_data  in  64  ciphertext or plain word.
REQ-004 SHALL have ports: in_ctrl  in  8  sideband control, carried with the word.
REQ-005 SHALL have ports: in_wr  in  1  word valid.
REQ-006 SHALL have ports: in_rdy  out  1  block can accept a word.
REQ-007 SHALL have ports: key  in  80  five 16-bit round keys, K4=key[79:64] ... K0=key[15:0].
REQ-008 SHALL have ports: inside_payload  in  1  word is ciphertext (1) or pass-through (0), qualified by in_wr.
REQ-009 SHALL have ports: out_data  out  64  decrypted or passed-through word.
REQ-010 SHALL have ports: out_ctrl  out  8  in_ctrl of the same word.
REQ-011 SHALL have ports: out_wr  out  1  out_data/out_ctrl valid.
REQ-012 SHALL have ports: out_rdy  in  1  downstream can accept.

Function
REQ-013 SHALL form a 6-slot pipeline: round slots R1..R5, then output slot O. Each slot holds valid, payload flag, ctrl, original in_data and round state.
REQ-014 SHALL use a single pipeline enable, en = out_rdy. When en=0, every slot holds its contents.
REQ-015 SHALL drive in_rdy = out_rdy combinationally. A word is accepted only when in_wr=1 and in_rdy=1. in_wr while in_rdy=0 is ignored, and upstream holds the word.
REQ-016 SHALL unpack the accepted word as w0=in[31:16], w1=in[15:0], w2=in[63:48], w3=in[47:32].
REQ-017 SHALL compute round j (j=1..5) in slot Rj with key K(j-1), i.e. R1 uses key[15:0] and R5 uses key[79:64].
REQ-018 SHALL compute each round, all arithmetic mod 2^16:
  - n0 = rotr3(w0) ^ K
  - n1 = w1 - K
  - n2 = w2 ^ n0
  - n3 = w3 ^ n1
  The n values of one round are the w values of the next.
REQ-019 SHALL sample key combinationally at each round when en=1. A key change mid-flight affects only rounds computed after the change.
REQ-020 SHALL load slot O, when en=1, with:
  - out_data = {n3,n2,n1,n0} of R5 if R5's payload flag=1
  - otherwise the untouched original in_data carried with the word.
REQ-021 SHALL drive out_wr = O.valid & out_rdy. out_data and out_ctrl are stable whenever O.valid=1.
REQ-022 SHALL give a latency of 6 enabled cycles: with out_rdy held high, a word accepted at edge t asserts out_wr in the cycle after edge t+5.
REQ-023 SHALL preserve order and count: every accepted word appears exactly once on out_wr, and bubbles (in_wr=0) propagate as invalid slots.
REQ-024 SHALL, on an out_rdy low pulse of N cycles, delay all in-flight words by exactly N cycles, with no loss or duplication.
REQ-025 SHALL carry payload flag and in_ctrl per word, so mixed payload/non-payload streams decode correctly word by word.

Reset
REQ-026 SHALL, with reset_n=0 at a rising edge, clear all slot valids, out_data=64'h0, out_ctrl=8'h0 and all round state to 0.
REQ-027 SHALL drop all in-flight words on reset mid-operation, and out_wr SHALL be 0 in the first cycle after reset.
REQ-028 SHALL take reset priority over en. in_rdy follows out_rdy during reset, but words presented during reset are discarded.

Verification
REQ-029 SHALL cover: key=80'h0001_0001_0001_0001_0001, in_data=64'h0, inside_payload=1, out_rdy=1 -> out_data=64'hFFFB_0411_FFFB_2491, 6 cycles later.
REQ-030 SHALL cover: key=0, in_data=64'h0, inside_payload=1 -> out_data=64'h0. Same stimulus with inside_payload=0 and in_data=64'h0123_4567_89AB_CDEF -> out_data=64'h0123_4567_89AB_CDEF.
REQ-031 SHALL cover: 10 back-to-back words with in_ctrl=1..10 and alternating inside_payload -> 10 out_wr pulses in order, out_ctrl=1..10, each word decrypted or passed per its flag.
REQ-032 SHALL cover: stream of 8 words with out_rdy low for 3 cycles mid-stream -> all 8 words delivered in order, with total completion time extended by exactly 3 cycles.
REQ-033 SHALL cover: reset_n low for 1 cycle with 4 words in flight -> no out_wr from those words, and the next accepted word emerges after 6 cycles.
REQ-034 SHALL cover: round trip, words from the team's 5-stage encryption block with the same key fed back in -> original plaintext recovered for 1000 random words and keys.

Source files
------------

// File: rtl/top_decryption.sv
// Five-round 64-bit word decryptor with a single out_rdy-driven pipeline enable.
// Non-payload words travel alongside the ciphertext and leave unchanged.
module top_decryption (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] in_data,
  input  logic [7:0]  in_ctrl,
  input  logic        in_wr,
  output logic        in_rdy,
  input  logic [79:0] key,
  input  logic        inside_payload,
  output logic [63:0] out_data,
  output logic [7:0]  out_ctrl,
  output logic        out_wr,
  input  logic        out_rdy
);

  // Handshake: a word moves on a rising edge only when in_wr=1 and in_rdy=1.
  // in_rdy mirrors out_rdy, so the whole pipeline advances or holds as one unit.
  logic en;
  assign en     = out_rdy;
  assign in_rdy = out_rdy;

  // Round state is packed as {w3, w2, w1, w0}, so the state after round 5
  // is already in output order {n3, n2, n1, n0}.
  function automatic logic [63:0] dec_round(input logic [63:0] s, input logic [15:0] k);
    logic [15:0] w0, w1, w2, w3, n0, n1;
    w0 = s[15:0];
    w1 = s[31:16];
    w2 = s[47:32];
    w3 = s[63:48];
    n0 = {w0[2:0], w0[15:3]} ^ k;
    n1 = w1 - k;
    return {w3 ^ n1, w2 ^ n0, n1, n0};
  endfunction

  logic [63:0] st_in;
  assign st_in = {in_data[47:32], in_data[63:48], in_data[15:0], in_data[31:16]};

  // Index i holds round slot R(i+1).
  logic [4:0]  vld;
  logic [4:0]  pay;
  logic [7:0]  ctrl [5];
  logic [63:0] orig [5];
  logic [63:0] st   [5];
  logic [63:0] nxt_st [5];
  logic        o_vld;

  always_comb begin
    for (int i = 0; i < 5; i++) nxt_st[i] = '0;
    nxt_st[0] = dec_round(st_in, key[15:0]);
    for (int i = 1; i < 5; i++) nxt_st[i] = dec_round(st[i-1], key[16*i +: 16]);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld      <= '0;
      pay      <= '0;
      o_vld    <= 1'b0;
      out_data <= '0;
      out_ctrl <= '0;
      for (int i = 0; i < 5; i++) begin
        ctrl[i] <= '0;
        orig[i] <= '0;
        st[i]   <= '0;
      end
    end else if (en) begin
      vld[0]  <= in_wr;
      pay[0]  <= inside_payload;
      ctrl[0] <= in_ctrl;
      orig[0] <= in_data;
      for (int i = 1; i < 5; i++) begin
        vld[i]  <= vld[i-1];
        pay[i]  <= pay[i-1];
        ctrl[i] <= ctrl[i-1];
        orig[i] <= orig[i-1];
      end
      for (int i = 0; i < 5; i++) st[i] <= nxt_st[i];
      o_vld    <= vld[4];
      out_data <= pay[4] ? st[4] : orig[4];
      out_ctrl <= ctrl[4];
    end
  end

  assign out_wr = o_vld & out_rdy;

endmodule

// File: tb/tb_top_decryption.sv
// Bench for top_decryption: constant vectors, latency/stall/reset sequences,
// and a round trip through a reference encryptor with random keys.
module tb_top_decryption;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        in_wr = 1'b0;
  logic        in_rdy;
  logic [79:0] key = '0;
  logic        inside_payload = 1'b0;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy = 1'b1;

  top_decryption dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_ctrl(in_ctrl),
    .in_wr(in_wr), .in_rdy(in_rdy), .key(key), .inside_payload(inside_payload),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [71:0] exp_q[$];
  int compared = 0;
  int mismatched = 0;
  int last_out_cyc = 0;
  bit rnd_stall = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_wr === 1'b1) begin
      logic [71:0] e;
      last_out_cyc = cyc;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL spurious_out_wr: got ctrl=%h data=%h with nothing expected", out_ctrl, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_ctrl, out_data} !== e) begin
          mismatched++;
          $display("FAIL out_word: got ctrl=%h data=%h expected ctrl=%h data=%h",
                   out_ctrl, out_data, e[71:64], e[63:0]);
        end
      end
    end
  end

  // ---------------- reference encryptor ----------------
  function automatic logic [63:0] encrypt(input logic [63:0] pt, input logic [79:0] k);
    logic [15:0] n0, n1, n2, n3, w0, w1, w2, w3, kk, t;
    n3 = pt[63:48]; n2 = pt[47:32]; n1 = pt[31:16]; n0 = pt[15:0];
    for (int j = 4; j >= 0; j--) begin
      kk = k[16*j +: 16];
      w3 = n3 ^ n1;
      w2 = n2 ^ n0;
      w1 = n1 + kk;
      t  = n0 ^ kk;
      w0 = {t[12:0], t[15:13]};
      n0 = w0; n1 = w1; n2 = w2; n3 = w3;
    end
    return {n2, n3, n0, n1};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic p, input logic [7:0] c, input logic [63:0] e);
    bit done = 0;
    in_data = d; inside_payload = p; in_ctrl = c; in_wr = 1'b1;
    while (!done) begin
      if (rnd_stall) out_rdy = ($urandom_range(0, 4) != 0);
      if (out_rdy) begin
        exp_q.push_back({c, e});
        done = 1;
      end
      step();
    end
    in_wr = 1'b0;
  endtask

  task automatic drain();
    out_rdy = 1'b1;
    in_wr = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain_timeout: got %0d words outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic send_random(input logic [79:0] k, input logic p, input logic [7:0] c);
    logic [63:0] pt;
    pt = {$urandom, $urandom};
    send(p ? encrypt(pt, k) : pt, p, c, pt);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [79:0] key;
    logic [63:0] data;
    logic        pay;
    logic [7:0]  ctrl;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int c0, d0, d1;
    logic [79:0] k;

    vecs[0] = '{80'h0001_0001_0001_0001_0001, 64'h0, 1'b1, 8'hA5, 64'hFFFB_0411_FFFB_2491};
    vecs[1] = '{80'h0, 64'h0, 1'b1, 8'h01, 64'h0};
    vecs[2] = '{80'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 8'h02, 64'h0123_4567_89AB_CDEF};
    vecs[3] = '{{80{1'b1}}, 64'hFEDC_BA98_7654_3210, 1'b0, 8'hFF, 64'hFEDC_BA98_7654_3210};

    // Reset: a word presented during reset must be discarded.
    in_data = 64'hDEAD_BEEF_0000_1111; in_wr = 1'b1; inside_payload = 1'b1;
    repeat (3) step();
    check("reset_out_wr", {63'h0, out_wr}, 64'h0);
    check("reset_out_data", out_data, 64'h0);
    check("reset_out_ctrl", {56'h0, out_ctrl}, 64'h0);
    check("reset_in_rdy_hi", {63'h0, in_rdy}, 64'h1);
    out_rdy = 1'b0; #1;
    check("reset_in_rdy_lo", {63'h0, in_rdy}, 64'h0);
    out_rdy = 1'b1; in_wr = 1'b0;
    reset_n = 1'b1;
    repeat (10) step();

    // Table-driven single words; first one also checks latency.
    for (int i = 0; i < 4; i++) begin
      key = vecs[i].key;
      c0 = cyc;
      send(vecs[i].data, vecs[i].pay, vecs[i].ctrl, vecs[i].exp);
      drain();
      if (i == 0) check("latency_single", 64'(last_out_cyc - c0), 64'd6);
    end

    // Ten back-to-back words, ctrl 1..10, alternating payload.
    key = {16'($urandom), $urandom, $urandom};
    for (int i = 1; i <= 10; i++) send_random(key, i[0], 8'(i));
    drain();

    // Eight-word burst, then the same with a 3-cycle out_rdy stall.
    c0 = cyc;
    for (int i = 0; i < 8; i++) send_random(key, 1'($urandom_range(0, 1)), 8'(8'h20 + i));
    drain();
    d0 = last_out_cyc - c0;
    check("burst_duration", 64'(d0), 64'd13);

    c0 = cyc;
    for (int i = 0; i < 4; i++) send_random(key, 1'($urandom_range(0, 1)), 8'(8'h30 + i));
    out_rdy = 1'b0;
    in_wr = 1'b1; in_data = 64'h5555_AAAA_5555_AAAA;
    repeat (3) step();
    out_rdy = 1'b1;
    for (int i = 4; i < 8; i++) send_random(key, 1'($urandom_range(0, 1)), 8'(8'h30 + i));
    drain();
    d1 = last_out_cyc - c0;
    check("stall_extension", 64'(d1 - d0), 64'd3);

    // Reset with four words in flight.
    for (int i = 0; i < 4; i++) send_random(key, 1'b1, 8'(8'h40 + i));
    reset_n = 1'b0;
    exp_q.delete();
    step();
    reset_n = 1'b1;
    check("post_reset_out_wr", {63'h0, out_wr}, 64'h0);
    repeat (8) step();
    c0 = cyc;
    send_random(key, 1'b1, 8'h50);
    drain();
    check("latency_after_reset", 64'(last_out_cyc - c0), 64'd6);

    // Round trip: 1000 words over 50 random keys with random back-pressure.
    rnd_stall = 1;
    for (int b = 0; b < 50; b++) begin
      k = {16'($urandom), $urandom, $urandom};
      key = k;
      for (int i = 0; i < 20; i++)
        send_random(k, 1'($urandom_range(0, 3) != 0), 8'($urandom));
      drain();
    end
    rnd_stall = 0;

    repeat (10) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
